// File: rtl/frame_buffer_swap_controller.sv
// frame_buffer_swap_controller
// Double-buffer scheduler sitting between the renderer and vga_output.
// Owns the back-buffer write port, sharing it between renderer writes and a
// built-in clear engine, and commits renderer swap requests only inside a
// vertical-blanking window, at most one swap per window.
//
// Handshakes:
//   swap_req is a level held by the renderer until it sees swap_ack, a
//   one-cycle pulse in the cycle the swap is committed. The request is only
//   sampled while rendering.
//   render_enable high means a render_we strobe in that cycle is accepted and
//   appears on bb_* one cycle later. A strobe while render_enable is low is
//   dropped.
`timescale 1ns/1ps

module frame_buffer_swap_controller #(
    parameter int                    ADDR_WIDTH    = 19,
    parameter int                    DATA_WIDTH    = 12,
    parameter int                    CLEAR_DEPTH   = 307200,
    parameter logic [DATA_WIDTH-1:0] CLEAR_COLOR   = {DATA_WIDTH{1'b0}},
    parameter bit                    CLEAR_ON_SWAP = 1'b1
) (
    input  logic                  pixel_clk,
    input  logic                  rst,
    input  logic                  frame_buffer_swap_allowed,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  render_enable,
    input  logic                  render_we,
    input  logic [ADDR_WIDTH-1:0] render_addr,
    input  logic [DATA_WIDTH-1:0] render_data,
    output logic                  front_sel,
    output logic                  bb_sel,
    output logic                  bb_we,
    output logic [ADDR_WIDTH-1:0] bb_addr,
    output logic [DATA_WIDTH-1:0] bb_data,
    output logic [15:0]           frame_count
);

    typedef enum logic [1:0] {
        ST_CLEAR       = 2'd0,
        ST_RENDER      = 2'd1,
        ST_WAIT_WINDOW = 2'd2,
        ST_SWAP        = 2'd3
    } state_t;

    // With clearing enabled, both reset and every swap hand the renderer a
    // freshly cleared back buffer; otherwise the renderer gets it straight away.
    localparam state_t FRESH_STATE = CLEAR_ON_SWAP ? ST_CLEAR : ST_RENDER;

    // Address of the final clear write; the counter wraps to zero after it.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CLEAR_DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clear_cnt;
    logic                  window_used;
    logic                  window_open;
    logic                  enter_swap;

    // A window is usable only if no swap has been committed in it yet.
    assign window_open = frame_buffer_swap_allowed && !window_used;
    assign enter_swap  = (state == ST_WAIT_WINDOW) && window_open;

    // Remember that the current blanking window has been spent; a low
    // allowed level closes the window and re-arms it. Setting has priority.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            window_used <= 1'b0;
        end else if (enter_swap) begin
            window_used <= 1'b1;
        end else if (!frame_buffer_swap_allowed) begin
            window_used <= 1'b0;
        end
    end

    // Main scheduler: state, swap bookkeeping and the registered write port.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state         <= FRESH_STATE;
            render_enable <= (FRESH_STATE == ST_RENDER);
            front_sel     <= 1'b0;
            bb_sel        <= 1'b1;
            swap_ack      <= 1'b0;
            bb_we         <= 1'b0;
            bb_addr       <= '0;
            bb_data       <= '0;
            frame_count   <= '0;
            clear_cnt     <= '0;
        end else begin
            // Pulses and strobes default low; address/data hold their value.
            swap_ack <= 1'b0;
            bb_we    <= 1'b0;

            case (state)
                ST_RENDER: begin
                    // The write presented alongside a swap request still lands.
                    if (render_we) begin
                        bb_we   <= 1'b1;
                        bb_addr <= render_addr;
                        bb_data <= render_data;
                    end
                    if (swap_req) begin
                        state         <= ST_WAIT_WINDOW;
                        render_enable <= 1'b0;
                    end
                end

                ST_WAIT_WINDOW: begin
                    // Renderer writes are dropped here; only wait for a window.
                    if (window_open) begin
                        state       <= ST_SWAP;
                        swap_ack    <= 1'b1;
                        front_sel   <= ~front_sel;
                        bb_sel      <= front_sel;
                        frame_count <= frame_count + 16'd1;
                    end
                end

                ST_SWAP: begin
                    // Single-cycle commit state while the ack pulse is visible.
                    state         <= FRESH_STATE;
                    render_enable <= (FRESH_STATE == ST_RENDER);
                end

                ST_CLEAR: begin
                    bb_we   <= 1'b1;
                    bb_addr <= clear_cnt;
                    bb_data <= CLEAR_COLOR;
                    if (clear_cnt == LAST_ADDR) begin
                        clear_cnt     <= '0;
                        state         <= ST_RENDER;
                        render_enable <= 1'b1;
                    end else begin
                        clear_cnt <= clear_cnt + ADDR_WIDTH'(1);
                    end
                end

                default: begin
                    state         <= FRESH_STATE;
                    render_enable <= (FRESH_STATE == ST_RENDER);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_swap_controller.sv
// Directed bench for frame_buffer_swap_controller.
// dut_a clears after reset and after every swap (16-entry clear, color ABC);
// dut_b never clears and covers the one-swap-per-window rule.
`timescale 1ns/1ps

module tb_frame_buffer_swap_controller;

    localparam int          AW    = 19;
    localparam int          DW    = 12;
    localparam int          DEPTH = 16;
    localparam logic [11:0] COLOR = 12'hABC;

    // clock / reset / shared stimulus
    logic          pixel_clk = 1'b0;
    logic          rst;
    logic          allowed;
    logic          render_we;
    logic [AW-1:0] render_addr;
    logic [DW-1:0] render_data;
    logic          swap_req_a;
    logic          swap_req_b;

    always #5 pixel_clk = ~pixel_clk;

    // dut_a outputs
    logic          a_swap_ack, a_render_enable, a_front_sel, a_bb_sel, a_bb_we;
    logic [AW-1:0] a_bb_addr;
    logic [DW-1:0] a_bb_data;
    logic [15:0]   a_frame_count;

    // dut_b outputs
    logic          b_swap_ack, b_render_enable, b_front_sel, b_bb_sel, b_bb_we;
    logic [AW-1:0] b_bb_addr;
    logic [DW-1:0] b_bb_data;
    logic [15:0]   b_frame_count;

    frame_buffer_swap_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_DEPTH(DEPTH),
        .CLEAR_COLOR(COLOR), .CLEAR_ON_SWAP(1'b1)
    ) dut_a (
        .pixel_clk(pixel_clk), .rst(rst),
        .frame_buffer_swap_allowed(allowed),
        .swap_req(swap_req_a), .swap_ack(a_swap_ack),
        .render_enable(a_render_enable), .render_we(render_we),
        .render_addr(render_addr), .render_data(render_data),
        .front_sel(a_front_sel), .bb_sel(a_bb_sel), .bb_we(a_bb_we),
        .bb_addr(a_bb_addr), .bb_data(a_bb_data), .frame_count(a_frame_count)
    );

    frame_buffer_swap_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_DEPTH(DEPTH),
        .CLEAR_COLOR(COLOR), .CLEAR_ON_SWAP(1'b0)
    ) dut_b (
        .pixel_clk(pixel_clk), .rst(rst),
        .frame_buffer_swap_allowed(allowed),
        .swap_req(swap_req_b), .swap_ack(b_swap_ack),
        .render_enable(b_render_enable), .render_we(render_we),
        .render_addr(render_addr), .render_data(render_data),
        .front_sel(b_front_sel), .bb_sel(b_bb_sel), .bb_we(b_bb_we),
        .bb_addr(b_bb_addr), .bb_data(b_bb_data), .frame_count(b_frame_count)
    );

    int checks = 0;
    int errors = 0;

    // single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // advance one active edge, then settle past it before sampling/driving
    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    // DEPTH clear writes on dut_a; optionally strobe renderer writes meanwhile
    task automatic run_clear(input string tag, input logic exp_sel, input bit poke);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            check({tag, "_we"},   32'(a_bb_we),   32'd1);
            check({tag, "_addr"}, 32'(a_bb_addr), 32'(i));
            check({tag, "_data"}, 32'(a_bb_data), 32'(COLOR));
            check({tag, "_sel"},  32'(a_bb_sel),  32'(exp_sel));
            if (i < DEPTH - 1)
                check({tag, "_ren"}, 32'(a_render_enable), 32'd0);
            render_we   = poke && (i < DEPTH - 1);
            render_addr = AW'(100 + i);
            render_data = 12'h555;
        end
        render_we = 1'b0;
    endtask

    // runaway guard
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        allowed     = 1'b0;
        render_we   = 1'b0;
        render_addr = '0;
        render_data = '0;
        swap_req_a  = 1'b0;
        swap_req_b  = 1'b0;
        step();
        step();

        // reset state
        check("rst_we",    32'(a_bb_we),         32'd0);
        check("rst_addr",  32'(a_bb_addr),       32'd0);
        check("rst_data",  32'(a_bb_data),       32'd0);
        check("rst_front", 32'(a_front_sel),     32'd0);
        check("rst_bbsel", 32'(a_bb_sel),        32'd1);
        check("rst_ren",   32'(a_render_enable), 32'd0);
        check("rst_ack",   32'(a_swap_ack),      32'd0);
        check("rst_fc",    32'(a_frame_count),   32'd0);
        check("rst_b_ren", 32'(b_render_enable), 32'd1);

        // reset clear, with renderer strobes that must be dropped
        rst = 1'b0;
        run_clear("rclr", 1'b1, 1'b1);
        step();
        check("post_clr_we",    32'(a_bb_we),         32'd0);
        check("post_clr_ren",   32'(a_render_enable), 32'd1);
        check("post_clr_front", 32'(a_front_sel),     32'd0);

        // render pass-through, back to back
        render_we = 1'b1; render_addr = AW'(5); render_data = 12'h123;
        step();
        check("pt_we",   32'(a_bb_we),   32'd1);
        check("pt_addr", 32'(a_bb_addr), 32'd5);
        check("pt_data", 32'(a_bb_data), 32'h123);
        render_addr = 19'h7FFFF; render_data = 12'hFFF;
        step();
        check("pt2_addr", 32'(a_bb_addr), 32'h7FFFF);
        check("pt2_data", 32'(a_bb_data), 32'hFFF);
        render_we = 1'b0;
        step();
        check("pt_idle_we", 32'(a_bb_we), 32'd0);

        // basic swap: request with a same-cycle write, window closed
        swap_req_a = 1'b1; render_we = 1'b1; render_addr = AW'(9); render_data = 12'h321;
        step();
        check("req_we",   32'(a_bb_we),         32'd1);
        check("req_addr", 32'(a_bb_addr),       32'd9);
        check("req_data", 32'(a_bb_data),       32'h321);
        check("req_ren",  32'(a_render_enable), 32'd0);
        check("req_ack",  32'(a_swap_ack),      32'd0);
        render_addr = AW'(10); render_data = 12'h777;
        for (int k = 0; k < 3; k++) begin
            step();
            check("wait_we",  32'(a_bb_we),         32'd0);
            check("wait_ack", 32'(a_swap_ack),      32'd0);
            check("wait_ren", 32'(a_render_enable), 32'd0);
        end
        render_we = 1'b0;
        allowed = 1'b1;
        step();
        check("sw1_ack",   32'(a_swap_ack),    32'd1);
        check("sw1_front", 32'(a_front_sel),   32'd1);
        check("sw1_bbsel", 32'(a_bb_sel),      32'd0);
        check("sw1_fc",    32'(a_frame_count), 32'd1);
        swap_req_a = 1'b0;
        step();
        check("sw1_ack_end", 32'(a_swap_ack), 32'd0);
        check("sw1_gap_we",  32'(a_bb_we),    32'd0);
        run_clear("sclr", 1'b0, 1'b1);
        step();
        check("sw1_done_ren", 32'(a_render_enable), 32'd1);
        check("sw1_done_fc",  32'(a_frame_count),   32'd1);
        check("sw1_done_we",  32'(a_bb_we),         32'd0);

        // second swap: fresh window already open when the request arrives
        allowed = 1'b0;
        step();
        allowed = 1'b1;
        step();
        swap_req_a = 1'b1;
        step();
        check("sw2_ack_early", 32'(a_swap_ack), 32'd0);
        step();
        check("sw2_ack",   32'(a_swap_ack),    32'd1);
        check("sw2_front", 32'(a_front_sel),   32'd0);
        check("sw2_fc",    32'(a_frame_count), 32'd2);
        swap_req_a = 1'b0;
        step();
        run_clear("s2clr", 1'b1, 1'b0);
        step();

        // third swap, then reset at the 7th clear write
        allowed = 1'b0;
        step();
        allowed = 1'b1; swap_req_a = 1'b1;
        step();
        step();
        check("sw3_ack",   32'(a_swap_ack),    32'd1);
        check("sw3_front", 32'(a_front_sel),   32'd1);
        check("sw3_fc",    32'(a_frame_count), 32'd3);
        swap_req_a = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            check("mid_addr", 32'(a_bb_addr), 32'(i));
        end
        rst = 1'b1;
        step();
        check("mrst_we",    32'(a_bb_we),         32'd0);
        check("mrst_fc",    32'(a_frame_count),   32'd0);
        check("mrst_front", 32'(a_front_sel),     32'd0);
        check("mrst_bbsel", 32'(a_bb_sel),        32'd1);
        check("mrst_addr",  32'(a_bb_addr),       32'd0);
        check("mrst_ren",   32'(a_render_enable), 32'd0);
        rst = 1'b0;
        run_clear("r2clr", 1'b1, 1'b0);
        step();
        check("r2_ren", 32'(a_render_enable), 32'd1);

        // dut_b: one swap per window, window held open
        swap_req_b = 1'b1;
        step();
        check("b1_ack_early", 32'(b_swap_ack),      32'd0);
        check("b1_ren",       32'(b_render_enable), 32'd0);
        step();
        check("b1_ack",   32'(b_swap_ack),    32'd1);
        check("b1_front", 32'(b_front_sel),   32'd1);
        check("b1_bbsel", 32'(b_bb_sel),      32'd0);
        check("b1_fc",    32'(b_frame_count), 32'd1);
        swap_req_b = 1'b0;
        step();
        check("b1_ack_end", 32'(b_swap_ack),      32'd0);
        check("b1_ren_back", 32'(b_render_enable), 32'd1);
        swap_req_b = 1'b1;
        step();
        check("b2_ren", 32'(b_render_enable), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("b2_same_window_ack", 32'(b_swap_ack), 32'd0);
        end
        allowed = 1'b0;
        step();
        check("b2_closed_ack", 32'(b_swap_ack), 32'd0);
        allowed = 1'b1;
        step();
        check("b2_ack",   32'(b_swap_ack),    32'd1);
        check("b2_fc",    32'(b_frame_count), 32'd2);
        check("b2_front", 32'(b_front_sel),   32'd0);
        swap_req_b = 1'b0;
        step();
        check("b2_ack_end", 32'(b_swap_ack),      32'd0);
        check("b2_ren",     32'(b_render_enable), 32'd1);
        render_we = 1'b1; render_addr = AW'(3); render_data = 12'h0F0;
        step();
        check("b_pt_we",   32'(b_bb_we),   32'd1);
        check("b_pt_addr", 32'(b_bb_addr), 32'd3);
        check("b_pt_data", 32'(b_bb_data), 32'h0F0);
        render_we = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
